// File: rtl/mem_pkg.sv
// Shared encodings for the memory/control-unit handshake: access sizes,
// read/write direction and the MOC state machine states.
package mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } memState_t;

  // Size 2'b11 falls into the word case on purpose.
  function automatic logic isMisaligned(input logic [1:0] addrLow, input logic [1:0] size);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return addrLow[0];
      default: return |addrLow;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane steering: alignment check, big-endian byte-lane enables
// for writes and right-justified, sign/zero-extended read data.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  addrLow,
  input  logic [1:0]  size,
  input  logic        unsignedLd,
  input  logic [31:0] rawWord,
  input  logic [31:0] writeData,
  output logic        misaligned,
  output logic [3:0]  laneEn,
  output logic [31:0] laneData,
  output logic [31:0] readData
);

  // Lane 3 / bits [31:24] always map to the addressed byte A, lane 0 to A+3.
  always_comb begin
    misaligned = isMisaligned(addrLow, size);
    laneEn     = 4'b1111;
    laneData   = writeData;
    readData   = rawWord;
    case (size)
      SZ_BYTE: begin
        laneEn   = 4'b1000;
        laneData = {writeData[7:0], 24'h0};
        readData = unsignedLd ? {24'h0, rawWord[31:24]}
                              : {{24{rawWord[31]}}, rawWord[31:24]};
      end
      SZ_HALF: begin
        laneEn   = 4'b1100;
        laneData = {writeData[15:0], 16'h0};
        readData = unsignedLd ? {16'h0, rawWord[31:16]}
                              : {{16{rawWord[31]}}, rawWord[31:16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_moc_ram.sv
// Byte-addressable big-endian memory answering the control unit's
// request/MOC four-phase handshake with a programmable number of wait states.
module mem_moc_ram
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = 512,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_enable,
  input  logic        rw,
  input  logic [1:0]  size,
  input  logic        unsigned_ld,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        busy,
  output logic        misaligned
);

  localparam int AW = $clog2(DEPTH_BYTES);

  memState_t     state;
  logic [3:0]    waitCnt;
  logic          capRw;
  logic          capUnsigned;
  logic [1:0]    capSize;
  logic [AW-1:0] capAddr;
  logic [31:0]   capData;

  logic [7:0]    memArray [DEPTH_BYTES];

  logic [AW-1:0] addr1, addr2, addr3;
  logic [31:0]   rawWord, laneData, readData;
  logic [3:0]    laneEn;
  logic          alignFault;
  logic          accessNow;
  logic          doWrite;
  logic          unusedAddrHi;

  // Upper address bits are dropped so accesses wrap modulo the array size.
  assign unusedAddrHi = ^address[31:AW];

  assign addr1   = capAddr + AW'(1);
  assign addr2   = capAddr + AW'(2);
  assign addr3   = capAddr + AW'(3);
  assign rawWord = {memArray[capAddr], memArray[addr1], memArray[addr2], memArray[addr3]};

  mem_lane_align uAlign (
    .addrLow    (capAddr[1:0]),
    .size       (capSize),
    .unsignedLd (capUnsigned),
    .rawWord    (rawWord),
    .writeData  (capData),
    .misaligned (alignFault),
    .laneEn     (laneEn),
    .laneData   (laneData),
    .readData   (readData)
  );

  assign accessNow = (state == ST_WAIT) && (waitCnt == 4'd0);
  assign doWrite   = accessNow && (capRw == RW_WRITE) && !alignFault;

  // Storage is deliberately not reset; a write only lands on the final WAIT edge.
  always_ff @(posedge clk) begin
    if (doWrite) begin
      if (laneEn[3]) memArray[capAddr] <= laneData[31:24];
      if (laneEn[2]) memArray[addr1]   <= laneData[23:16];
      if (laneEn[1]) memArray[addr2]   <= laneData[15:8];
      if (laneEn[0]) memArray[addr3]   <= laneData[7:0];
    end
  end

  // Handshake FSM: capture in IDLE, count down in WAIT, hold MOC in DONE
  // until the control unit drops its request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      waitCnt     <= 4'd0;
      moc         <= 1'b0;
      busy        <= 1'b0;
      misaligned  <= 1'b0;
      data_out    <= 32'h0;
      capRw       <= RW_READ;
      capUnsigned <= 1'b0;
      capSize     <= SZ_BYTE;
      capAddr     <= '0;
      capData     <= 32'h0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mem_enable) begin
            capRw       <= rw;
            capSize     <= size;
            capUnsigned <= unsigned_ld;
            capAddr     <= address[AW-1:0];
            capData     <= data_in;
            waitCnt     <= 4'(WAIT_STATES);
            busy        <= 1'b1;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (waitCnt == 4'd0) begin
            misaligned <= alignFault;
            if (alignFault) begin
              data_out <= 32'h0;
            end else if (capRw == RW_READ) begin
              data_out <= readData;
            end
            moc   <= 1'b1;
            state <= ST_DONE;
          end else begin
            waitCnt <= waitCnt - 4'd1;
          end
        end
        ST_DONE: begin
          if (!mem_enable) begin
            moc   <= 1'b0;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: begin
          moc   <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_moc_ram.sv
// Self-checking bench for mem_moc_ram: byte-array reference model, directed
// scenarios with literal expectations and a randomized transaction mix.
module tb_mem_moc_ram;

  localparam int DEPTH = 512;
  localparam int WS    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_enable;
  logic        rw;
  logic [1:0]  size;
  logic        unsigned_ld;
  logic [31:0] address;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        moc;
  logic        busy;
  logic        misaligned;

  int testsRun  = 0;
  int failCount = 0;

  logic [7:0]  model [DEPTH];
  logic [31:0] expData  = 32'h0;
  logic        expMis   = 1'b0;
  logic [31:0] prevData = 32'h0;
  logic [31:0] gotData;
  logic        gotMis;

  mem_moc_ram #(.DEPTH_BYTES(DEPTH), .WAIT_STATES(WS)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem_enable  (mem_enable),
    .rw          (rw),
    .size        (size),
    .unsigned_ld (unsigned_ld),
    .address     (address),
    .data_in     (data_in),
    .data_out    (data_out),
    .moc         (moc),
    .busy        (busy),
    .misaligned  (misaligned)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sizeBytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] modelLoad(input logic [31:0] a, input logic [1:0] sz, input logic u);
    int n = sizeBytes(sz);
    int base = int'(a % DEPTH);
    logic [31:0] v = 32'h0;
    for (int i = 0; i < n; i++) v = (v << 8) | 32'(model[(base + i) % DEPTH]);
    if (!u && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
    return v;
  endfunction

  // Computes the expected completion of one request and updates the model array.
  task automatic modelAccept(input logic r, input logic [1:0] sz, input logic u,
                             input logic [31:0] a, input logic [31:0] d);
    int n = sizeBytes(sz);
    int base = int'(a % DEPTH);
    if ((a % n) != 0) begin
      expMis  = 1'b1;
      expData = 32'h0;
    end else begin
      expMis = 1'b0;
      if (r) begin
        expData = modelLoad(a, sz, u);
      end else begin
        for (int i = 0; i < n; i++) model[(base + i) % DEPTH] = 8'(d >> (8 * (n - 1 - i)));
        expData = prevData;
      end
    end
    prevData = expData;
  endtask

  // Every cycle with MOC high, the completion outputs must match the model.
  always @(negedge clk) begin
    if (!reset && moc) begin
      checkOutput("dataOutAtMoc", data_out, expData);
      checkOutput("misalignedAtMoc", 32'(misaligned), 32'(expMis));
      checkOutput("busyAtMoc", 32'(busy), 32'h1);
    end
  end

  // One full handshake; inputs are scrambled after capture to prove they are ignored.
  task automatic applyStimulus(input logic r, input logic [1:0] sz, input logic u,
                               input logic [31:0] a, input logic [31:0] d,
                               input int holdExtra, input bit dropEarly);
    int cycles;
    @(negedge clk);
    rw = r; size = sz; unsigned_ld = u; address = a; data_in = d; mem_enable = 1'b1;
    modelAccept(r, sz, u, a, d);
    @(posedge clk); #1;
    cycles = 1;
    checkOutput("busyAfterAccept", 32'(busy), 32'h1);
    @(negedge clk);
    rw = 1'($urandom); size = 2'($urandom); unsigned_ld = 1'($urandom);
    address = $urandom; data_in = $urandom;
    if (dropEarly) mem_enable = 1'b0;
    while (!moc && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    checkOutput("mocLatency", 32'(cycles), 32'(WS + 2));
    gotData = data_out;
    gotMis  = misaligned;
    if (dropEarly) begin
      @(posedge clk); #1;
      checkOutput("mocPulseFall", 32'(moc), 32'h0);
    end else begin
      for (int i = 0; i < holdExtra; i++) begin
        @(posedge clk); #1;
        checkOutput("mocHeld", 32'(moc), 32'h1);
      end
      @(negedge clk);
      mem_enable = 1'b0;
      @(posedge clk); #1;
      checkOutput("mocFall", 32'(moc), 32'h0);
    end
    checkOutput("busyFall", 32'(busy), 32'h0);
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] a;
    bit sawMoc;
    reset = 1'b1; mem_enable = 1'b0; rw = 1'b1; size = 2'b10; unsigned_ld = 1'b0;
    address = 32'h0; data_in = 32'h0;
    for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
    #23;
    checkOutput("resetMoc", 32'(moc), 32'h0);
    checkOutput("resetBusy", 32'(busy), 32'h0);
    checkOutput("resetData", data_out, 32'h0);
    checkOutput("resetMis", 32'(misaligned), 32'h0);
    @(negedge clk); reset = 1'b0;

    // Fill the low 256 bytes so every later read has known contents.
    for (int i = 0; i < 64; i++) applyStimulus(1'b0, 2'b10, 1'b0, 32'(i * 4), $urandom, 0, 1'b0);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    checkOutput("modelWord10", modelLoad(32'h10, 2'b10, 1'b0), 32'hDEADBEEF);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    checkOutput("wordRead10", gotData, 32'hDEADBEEF);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    checkOutput("byteRead10", gotData, 32'hFFFFFFDE);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h11, 32'h0, 0, 1'b0);
    checkOutput("byteRead11", gotData, 32'hFFFFFFAD);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h12, 32'h0, 0, 1'b0);
    checkOutput("byteRead12", gotData, 32'hFFFFFFBE);
    applyStimulus(1'b1, 2'b00, 1'b0, 32'h13, 32'h0, 0, 1'b0);
    checkOutput("byteRead13", gotData, 32'hFFFFFFEF);
    applyStimulus(1'b1, 2'b00, 1'b1, 32'h11, 32'h0, 0, 1'b0);
    checkOutput("ubyteRead11", gotData, 32'h000000AD);

    applyStimulus(1'b0, 2'b01, 1'b0, 32'h12, 32'h00001234, 0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    checkOutput("wordAfterHalf", gotData, 32'hDEAD1234);
    checkOutput("modelAfterHalf", modelLoad(32'h10, 2'b10, 1'b0), 32'hDEAD1234);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h11, 32'h0, 0, 1'b0);
    checkOutput("halfMisData", gotData, 32'h0);
    checkOutput("halfMisFlag", 32'(gotMis), 32'h1);
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h11, 32'h55555555, 0, 1'b0);
    checkOutput("wordMisWrFlag", 32'(gotMis), 32'h1);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 0, 1'b0);
    checkOutput("memUnchanged", gotData, 32'hDEAD1234);

    applyStimulus(1'b0, 2'b10, 1'b0, 32'(DEPTH + 32'h20), 32'h0BADCAFE, 0, 1'b0);
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 0, 1'b0);
    checkOutput("wrapRead", gotData, 32'h0BADCAFE);

    applyStimulus(1'b1, 2'b01, 1'b1, 32'h12, 32'h0, 5, 1'b0);
    checkOutput("holdRead", gotData, 32'h00001234);
    applyStimulus(1'b1, 2'b01, 1'b0, 32'h10, 32'h0, 0, 1'b1);
    checkOutput("earlyDropRead", gotData, 32'hFFFFDEAD);

    // Reset during the WAIT of a write must drop the write.
    applyStimulus(1'b0, 2'b10, 1'b0, 32'h40, 32'hCAFEF00D, 0, 1'b0);
    @(negedge clk);
    rw = 1'b0; size = 2'b10; address = 32'h40; data_in = 32'h11111111; mem_enable = 1'b1;
    @(posedge clk); @(posedge clk);
    @(negedge clk); reset = 1'b1; mem_enable = 1'b0;
    #1;
    checkOutput("midResetMoc", 32'(moc), 32'h0);
    checkOutput("midResetBusy", 32'(busy), 32'h0);
    checkOutput("midResetData", data_out, 32'h0);
    checkOutput("midResetMis", 32'(misaligned), 32'h0);
    sawMoc = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (moc) sawMoc = 1'b1;
    end
    checkOutput("midResetNoMoc", 32'(sawMoc), 32'h0);
    @(negedge clk); reset = 1'b0;
    prevData = 32'h0;
    applyStimulus(1'b1, 2'b10, 1'b0, 32'h40, 32'h0, 0, 1'b0);
    checkOutput("writeDropped", gotData, 32'hCAFEF00D);

    for (int i = 0; i < 60; i++) begin
      a = $urandom & 32'hFFFF_FEFF;
      v = $urandom;
      applyStimulus(1'($urandom), 2'($urandom), 1'($urandom), a, v,
                    int'($urandom_range(0, 2)), ($urandom_range(0, 7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
